// File: rtl/ysyx_24100006_ifu_pf.sv
// Prefetching instruction-fetch unit: issues AXI INCR bursts ahead of the IF/ID handshake and
// buffers the returned words, with their PCs and fault flags, in a small fetch queue.
module ysyx_24100006_ifu_pf #(
   parameter int unsigned FIFO_DEPTH  = 4,
   parameter int unsigned BURST_BEATS = 4,
   parameter logic [31:0] RESET_PC    = 32'h3000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic [31:0] axi_araddr,
   output logic        axi_arvalid,
   input  logic        axi_arready,
   output logic [7:0]  axi_arlen,
   output logic [2:0]  axi_arsize,
   output logic [1:0]  axi_arburst,
   input  logic        axi_rvalid,
   output logic        axi_rready,
   input  logic [31:0] axi_rdata,
   input  logic [1:0]  axi_rresp,
   input  logic        axi_rlast,
   output logic        if_out_valid,
   input  logic        if_out_ready,
   output logic [31:0] pc_F,
   output logic [31:0] inst_F,
   output logic        fault_F
);

   localparam int unsigned PtrW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CntW      = $clog2(FIFO_DEPTH + 1);
   localparam logic [31:0] BurstMask = 32'(BURST_BEATS * 4 - 1);
   localparam logic [7:0]  FullLen   = 8'(BURST_BEATS - 1);

   typedef enum logic [1:0] {StIdle, StAr, StR, StHalt} state_e;

   state_e          state_q, state_d;
   logic [31:0]     fpc_q, fpc_d;
   logic [31:0]     araddr_q, araddr_d;
   logic [31:0]     beat_addr_q, beat_addr_d;
   logic [7:0]      arlen_q, arlen_d;
   logic            arvalid_q, arvalid_d;
   logic            rready_q, rready_d;
   logic            drop_q, drop_d;
   logic            halt_pend_q, halt_pend_d;
   logic [CntW-1:0] count_q, count_d;
   logic [CntW-1:0] resv_q, resv_d;
   logic [PtrW-1:0] wptr_q, wptr_d;
   logic [PtrW-1:0] rptr_q, rptr_d;

   logic [31:0] fifo_pc_q    [FIFO_DEPTH];
   logic [31:0] fifo_inst_q  [FIFO_DEPTH];
   logic        fifo_fault_q [FIFO_DEPTH];

   logic        fpc_aligned;
   logic [31:0] beats;
   logic [31:0] used;
   logic        can_issue;
   logic        beat_fire;
   logic        beat_fault;
   logic        enq;
   logic        deq;
   logic        out_valid;

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (32'(p) == FIFO_DEPTH - 1) ? '0 : p + PtrW'(1);
   endfunction

   // Bursts start only on a burst-aligned PC, so none can cross a burst boundary.
   assign fpc_aligned = (fpc_q & BurstMask) == 32'd0;
   assign beats       = fpc_aligned ? 32'(BURST_BEATS) : 32'd1;
   assign used        = 32'(count_q) + 32'(resv_q);
   assign can_issue   = (used + beats) <= 32'(FIFO_DEPTH);

   assign beat_fire  = (state_q == StR) && axi_rvalid && rready_q;
   assign beat_fault = axi_rresp != 2'b00;
   // A beat landing together with a redirect belongs to the stale stream.
   assign enq        = beat_fire && !drop_q && !redirect_valid;
   assign out_valid  = count_q != '0;
   assign deq        = out_valid && if_out_ready;

   always_comb begin
      state_d     = state_q;
      fpc_d       = fpc_q;
      araddr_d    = araddr_q;
      arlen_d     = arlen_q;
      arvalid_d   = arvalid_q;
      rready_d    = rready_q;
      beat_addr_d = beat_addr_q;
      drop_d      = drop_q;
      halt_pend_d = halt_pend_q;
      count_d     = count_q + CntW'(enq) - CntW'(deq);
      resv_d      = resv_q;
      wptr_d      = enq ? ptr_inc(wptr_q) : wptr_q;
      rptr_d      = deq ? ptr_inc(rptr_q) : rptr_q;

      if (beat_fire && (resv_q != '0)) begin
         resv_d = resv_q - CntW'(1);
      end

      unique case (state_q)
         StIdle: begin
            if (!redirect_valid && can_issue) begin
               state_d   = StAr;
               araddr_d  = fpc_q;
               arlen_d   = fpc_aligned ? FullLen : 8'd0;
               arvalid_d = 1'b1;
               resv_d    = resv_q + CntW'(beats);
            end
         end
         StAr: begin
            if (axi_arready) begin
               state_d     = StR;
               arvalid_d   = 1'b0;
               rready_d    = 1'b1;
               beat_addr_d = araddr_q;
               // A drained burst must not advance a PC that already points at the redirect.
               if (!drop_q) begin
                  fpc_d = fpc_q + ((32'(arlen_q) + 32'd1) << 2);
               end
            end
         end
         StR: begin
            if (beat_fire) begin
               beat_addr_d = beat_addr_q + 32'd4;
               if (!drop_q && beat_fault) begin
                  drop_d      = 1'b1;
                  halt_pend_d = 1'b1;
               end
               if (axi_rlast) begin
                  rready_d    = 1'b0;
                  drop_d      = 1'b0;
                  halt_pend_d = 1'b0;
                  state_d     = (halt_pend_q || (!drop_q && beat_fault)) ? StHalt : StIdle;
               end
            end
         end
         StHalt: begin
         end
      endcase

      if (redirect_valid) begin
         count_d     = '0;
         resv_d      = '0;
         wptr_d      = '0;
         rptr_d      = '0;
         fpc_d       = redirect_pc & 32'hFFFF_FFFC;
         halt_pend_d = 1'b0;
         case (state_q)
            StAr: drop_d = 1'b1;
            StR: begin
               if (beat_fire && axi_rlast) begin
                  drop_d  = 1'b0;
                  state_d = StIdle;
               end else begin
                  drop_d = 1'b1;
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= StIdle;
         fpc_q       <= RESET_PC;
         araddr_q    <= '0;
         arlen_q     <= '0;
         arvalid_q   <= 1'b0;
         rready_q    <= 1'b0;
         beat_addr_q <= '0;
         drop_q      <= 1'b0;
         halt_pend_q <= 1'b0;
         count_q     <= '0;
         resv_q      <= '0;
         wptr_q      <= '0;
         rptr_q      <= '0;
      end else begin
         state_q     <= state_d;
         fpc_q       <= fpc_d;
         araddr_q    <= araddr_d;
         arlen_q     <= arlen_d;
         arvalid_q   <= arvalid_d;
         rready_q    <= rready_d;
         beat_addr_q <= beat_addr_d;
         drop_q      <= drop_d;
         halt_pend_q <= halt_pend_d;
         count_q     <= count_d;
         resv_q      <= resv_d;
         wptr_q      <= wptr_d;
         rptr_q      <= rptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (enq) begin
         fifo_pc_q[wptr_q]    <= beat_addr_q;
         fifo_inst_q[wptr_q]  <= axi_rdata;
         fifo_fault_q[wptr_q] <= beat_fault;
      end
   end

   assign axi_araddr  = araddr_q;
   assign axi_arvalid = arvalid_q;
   assign axi_arlen   = arlen_q;
   assign axi_arsize  = 3'b010;
   assign axi_arburst = 2'b01;
   assign axi_rready  = rready_q;

   assign if_out_valid = out_valid;
   assign pc_F         = out_valid ? fifo_pc_q[rptr_q] : 32'd0;
   assign inst_F       = out_valid ? fifo_inst_q[rptr_q] : 32'd0;
   assign fault_F      = out_valid ? fifo_fault_q[rptr_q] : 1'b0;

endmodule

// File: tb/tb_ysyx_24100006_ifu_pf.sv
// Directed bench for the prefetching IFU: an AXI read slave returning word = address, and an
// output monitor logging every dequeued instruction.
module tb_ysyx_24100006_ifu_pf;

   logic        clk = 1'b0;
   logic        reset;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic [31:0] axi_araddr;
   logic        axi_arvalid;
   logic        axi_arready;
   logic [7:0]  axi_arlen;
   logic [2:0]  axi_arsize;
   logic [1:0]  axi_arburst;
   logic        axi_rvalid;
   logic        axi_rready;
   logic [31:0] axi_rdata;
   logic [1:0]  axi_rresp;
   logic        axi_rlast;
   logic        if_out_valid;
   logic        if_out_ready;
   logic [31:0] pc_F;
   logic [31:0] inst_F;
   logic        fault_F;

   ysyx_24100006_ifu_pf dut (
      .clk           (clk),
      .reset         (reset),
      .redirect_valid(redirect_valid),
      .redirect_pc   (redirect_pc),
      .axi_araddr    (axi_araddr),
      .axi_arvalid   (axi_arvalid),
      .axi_arready   (axi_arready),
      .axi_arlen     (axi_arlen),
      .axi_arsize    (axi_arsize),
      .axi_arburst   (axi_arburst),
      .axi_rvalid    (axi_rvalid),
      .axi_rready    (axi_rready),
      .axi_rdata     (axi_rdata),
      .axi_rresp     (axi_rresp),
      .axi_rlast     (axi_rlast),
      .if_out_valid  (if_out_valid),
      .if_out_ready  (if_out_ready),
      .pc_F          (pc_F),
      .inst_F        (inst_F),
      .fault_F       (fault_F)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [31:0] ar_addr_q [$];
   logic [7:0]  ar_len_q [$];
   logic [31:0] out_pc_q [$];
   logic [31:0] out_inst_q [$];
   logic        out_fault_q [$];

   int          beats_left;
   int          beats_fired;
   int          ar_stall;
   logic        fault_en;
   logic [31:0] fault_addr;
   logic [31:0] burst_addr;

   logic        s_arv, s_arrdy, s_rv, s_rrdy, s_ov, s_ordy, s_fault;
   logic [31:0] s_araddr, s_pc, s_inst;
   logic [7:0]  s_arlen;

   // Snapshot at the falling edge, act 2 time units after the rising edge it described.
   initial begin
      axi_arready = 1'b1;
      axi_rvalid  = 1'b0;
      axi_rdata   = '0;
      axi_rresp   = '0;
      axi_rlast   = 1'b0;
      beats_left  = 0;
      burst_addr  = '0;
      forever begin
         @(negedge clk);
         s_arv = axi_arvalid; s_arrdy = axi_arready; s_araddr = axi_araddr; s_arlen = axi_arlen;
         s_rv = axi_rvalid; s_rrdy = axi_rready;
         s_ov = if_out_valid; s_ordy = if_out_ready; s_pc = pc_F; s_inst = inst_F;
         s_fault = fault_F;
         @(posedge clk);
         #2;
         if (!reset) begin
            beats_left  = 0;
            axi_rvalid  = 1'b0;
            axi_rlast   = 1'b0;
            axi_arready = 1'b1;
         end else begin
            if (s_arv && s_arrdy) begin
               ar_addr_q.push_back(s_araddr);
               ar_len_q.push_back(s_arlen);
               burst_addr = s_araddr;
               beats_left = int'(s_arlen) + 1;
            end
            if (s_rv && s_rrdy) begin
               beats_fired++;
               burst_addr = burst_addr + 32'd4;
               beats_left--;
            end
            if (s_ov && s_ordy) begin
               out_pc_q.push_back(s_pc);
               out_inst_q.push_back(s_inst);
               out_fault_q.push_back(s_fault);
            end
            if (axi_arvalid && ar_stall > 0) begin
               axi_arready = 1'b0;
               ar_stall--;
            end else begin
               axi_arready = 1'b1;
            end
            axi_rvalid = beats_left > 0;
            axi_rdata  = burst_addr;
            axi_rresp  = (fault_en && burst_addr == fault_addr) ? 2'b10 : 2'b00;
            axi_rlast  = beats_left == 1;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #3;
   endtask

   task automatic clear_logs();
      ar_addr_q.delete(); ar_len_q.delete();
      out_pc_q.delete(); out_inst_q.delete(); out_fault_q.delete();
      beats_fired = 0;
   endtask

   task automatic do_reset(input logic rdy, input int stall, input logic fen,
                           input logic [31:0] faddr);
      reset = 1'b0;
      redirect_valid = 1'b0;
      tick();
      tick();
      clear_logs();
      if_out_ready = rdy;
      ar_stall = stall;
      fault_en = fen;
      fault_addr = faddr;
      reset = 1'b1;
   endtask

   task automatic wait_out(input int n, input int budget);
      for (int c = 0; c < budget && out_pc_q.size() < n; c++) tick();
   endtask

   task automatic wait_ar(input int n, input int budget);
      for (int c = 0; c < budget && ar_addr_q.size() < n; c++) tick();
   endtask

   task automatic wait_beats(input int n, input int budget);
      for (int c = 0; c < budget && beats_fired < n; c++) tick();
   endtask

   task automatic test_reset();
      tick();
      tick();
      checks += 10;
      if (axi_arvalid !== 1'b0) begin errors++; $display("FAIL rst_arvalid got %b exp 0", axi_arvalid); end
      if (axi_rready !== 1'b0) begin errors++; $display("FAIL rst_rready got %b exp 0", axi_rready); end
      if (axi_araddr !== 32'd0) begin errors++; $display("FAIL rst_araddr got %h exp 0", axi_araddr); end
      if (axi_arlen !== 8'd0) begin errors++; $display("FAIL rst_arlen got %h exp 0", axi_arlen); end
      if (axi_arsize !== 3'b010) begin errors++; $display("FAIL rst_arsize got %b exp 010", axi_arsize); end
      if (axi_arburst !== 2'b01) begin errors++; $display("FAIL rst_arburst got %b exp 01", axi_arburst); end
      if (if_out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", if_out_valid); end
      if (pc_F !== 32'd0) begin errors++; $display("FAIL rst_pc got %h exp 0", pc_F); end
      if (inst_F !== 32'd0) begin errors++; $display("FAIL rst_inst got %h exp 0", inst_F); end
      if (fault_F !== 1'b0) begin errors++; $display("FAIL rst_fault got %b exp 0", fault_F); end
      clear_logs();
      if_out_ready = 1'b0;
      ar_stall = 0;
      reset = 1'b1;
      tick();
      checks += 3;
      if (axi_arvalid !== 1'b1) begin errors++; $display("FAIL first_arvalid got %b exp 1", axi_arvalid); end
      if (axi_araddr !== 32'h3000_0000) begin errors++; $display("FAIL first_araddr got %h exp 30000000", axi_araddr); end
      if (axi_arlen !== 8'd3) begin errors++; $display("FAIL first_arlen got %0d exp 3", axi_arlen); end
   endtask

   task automatic test_streaming();
      logic [31:0] e;
      do_reset(1'b1, 0, 1'b0, 32'd0);
      wait_out(12, 300);
      checks++;
      if (out_pc_q.size() < 12) begin errors++; $display("FAIL stream_timeout got %0d exp 12", out_pc_q.size()); end
      for (int i = 0; i < 12; i++) begin
         e = 32'h3000_0000 + 32'(4 * i);
         checks++;
         if (out_pc_q[i] !== e || out_inst_q[i] !== e || out_fault_q[i] !== 1'b0) begin
            errors++;
            $display("FAIL stream_out[%0d] got pc %h inst %h f %b exp %h", i, out_pc_q[i], out_inst_q[i],
                     out_fault_q[i], e);
         end
      end
      for (int k = 0; k < 3; k++) begin
         e = 32'h3000_0000 + 32'(16 * k);
         checks++;
         if (ar_addr_q[k] !== e || ar_len_q[k] !== 8'd3) begin
            errors++;
            $display("FAIL stream_ar[%0d] got %h len %0d exp %h len 3", k, ar_addr_q[k], ar_len_q[k], e);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] e;
      do_reset(1'b0, 0, 1'b0, 32'd0);
      repeat (20) tick();
      checks += 3;
      if (ar_addr_q.size() !== 1) begin errors++; $display("FAIL bp_ar_count got %0d exp 1", ar_addr_q.size()); end
      if (ar_addr_q[0] !== 32'h3000_0000) begin errors++; $display("FAIL bp_ar_addr got %h exp 30000000", ar_addr_q[0]); end
      if (axi_arvalid !== 1'b0) begin errors++; $display("FAIL bp_arvalid got %b exp 0", axi_arvalid); end
      for (int c = 0; c < 4; c++) begin
         checks++;
         if (if_out_valid !== 1'b1 || pc_F !== 32'h3000_0000 || inst_F !== 32'h3000_0000) begin
            errors++;
            $display("FAIL bp_hold got v %b pc %h inst %h exp 1 30000000", if_out_valid, pc_F, inst_F);
         end
         tick();
      end
      if_out_ready = 1'b1;
      wait_out(8, 200);
      for (int i = 0; i < 8; i++) begin
         e = 32'h3000_0000 + 32'(4 * i);
         checks++;
         if (out_pc_q[i] !== e) begin errors++; $display("FAIL bp_out[%0d] got %h exp %h", i, out_pc_q[i], e); end
      end
      checks++;
      if (ar_addr_q[1] !== 32'h3000_0010) begin errors++; $display("FAIL bp_ar1 got %h exp 30000010", ar_addr_q[1]); end
   endtask

   task automatic test_redirect_mid_burst();
      logic [31:0] exp_out [6];
      logic [31:0] exp_ar [4];
      logic [7:0]  exp_len [4];
      exp_out = '{32'h3000_0000, 32'h3000_0004, 32'h8000_0008, 32'h8000_000C, 32'h8000_0010,
                  32'h8000_0014};
      exp_ar  = '{32'h3000_0000, 32'h8000_0008, 32'h8000_000C, 32'h8000_0010};
      exp_len = '{8'd3, 8'd0, 8'd0, 8'd3};
      do_reset(1'b1, 0, 1'b0, 32'd0);
      wait_beats(2, 50);
      checks++;
      if (beats_fired !== 2) begin errors++; $display("FAIL mid_beats got %0d exp 2", beats_fired); end
      redirect_valid = 1'b1;
      redirect_pc = 32'h8000_0008;
      tick();
      redirect_valid = 1'b0;
      checks++;
      if (axi_rready !== 1'b1) begin errors++; $display("FAIL mid_rready got %b exp 1", axi_rready); end
      wait_out(6, 300);
      wait_ar(4, 100);
      for (int i = 0; i < 6; i++) begin
         checks++;
         if (out_pc_q[i] !== exp_out[i] || out_inst_q[i] !== exp_out[i]) begin
            errors++;
            $display("FAIL mid_out[%0d] got %h/%h exp %h", i, out_pc_q[i], out_inst_q[i], exp_out[i]);
         end
      end
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (ar_addr_q[k] !== exp_ar[k] || ar_len_q[k] !== exp_len[k]) begin
            errors++;
            $display("FAIL mid_ar[%0d] got %h len %0d exp %h len %0d", k, ar_addr_q[k], ar_len_q[k],
                     exp_ar[k], exp_len[k]);
         end
      end
   endtask

   task automatic test_redirect_in_ar();
      logic [31:0] e;
      do_reset(1'b1, 3, 1'b0, 32'd0);
      tick();
      redirect_valid = 1'b1;
      redirect_pc = 32'h4000_0000;
      for (int c = 0; c < 3; c++) begin
         checks++;
         if (axi_arvalid !== 1'b1 || axi_araddr !== 32'h3000_0000) begin
            errors++;
            $display("FAIL ar_hold[%0d] got v %b addr %h exp 1 30000000", c, axi_arvalid, axi_araddr);
         end
         tick();
         redirect_valid = 1'b0;
      end
      wait_out(4, 300);
      wait_ar(2, 100);
      checks += 2;
      if (ar_addr_q[0] !== 32'h3000_0000) begin errors++; $display("FAIL ar_first got %h exp 30000000", ar_addr_q[0]); end
      if (ar_addr_q[1] !== 32'h4000_0000 || ar_len_q[1] !== 8'd3) begin
         errors++;
         $display("FAIL ar_redir got %h len %0d exp 40000000 len 3", ar_addr_q[1], ar_len_q[1]);
      end
      for (int i = 0; i < 4; i++) begin
         e = 32'h4000_0000 + 32'(4 * i);
         checks++;
         if (out_pc_q[i] !== e) begin errors++; $display("FAIL ar_out[%0d] got %h exp %h", i, out_pc_q[i], e); end
      end
   endtask

   task automatic test_fault();
      do_reset(1'b1, 0, 1'b1, 32'h3000_0004);
      wait_out(2, 100);
      checks += 2;
      if (out_pc_q[0] !== 32'h3000_0000 || out_fault_q[0] !== 1'b0) begin
         errors++;
         $display("FAIL flt_out0 got %h f %b exp 30000000 f 0", out_pc_q[0], out_fault_q[0]);
      end
      if (out_pc_q[1] !== 32'h3000_0004 || out_fault_q[1] !== 1'b1) begin
         errors++;
         $display("FAIL flt_out1 got %h f %b exp 30000004 f 1", out_pc_q[1], out_fault_q[1]);
      end
      repeat (20) tick();
      checks += 4;
      if (ar_addr_q.size() !== 1) begin errors++; $display("FAIL flt_ar_count got %0d exp 1", ar_addr_q.size()); end
      if (axi_arvalid !== 1'b0) begin errors++; $display("FAIL flt_arvalid got %b exp 0", axi_arvalid); end
      if (if_out_valid !== 1'b0) begin errors++; $display("FAIL flt_valid got %b exp 0", if_out_valid); end
      if (out_pc_q.size() !== 2) begin errors++; $display("FAIL flt_out_count got %0d exp 2", out_pc_q.size()); end
      redirect_valid = 1'b1;
      redirect_pc = 32'h3000_0100;
      tick();
      redirect_valid = 1'b0;
      wait_out(4, 200);
      checks += 3;
      if (ar_addr_q[1] !== 32'h3000_0100 || ar_len_q[1] !== 8'd3) begin
         errors++;
         $display("FAIL flt_ar1 got %h len %0d exp 30000100 len 3", ar_addr_q[1], ar_len_q[1]);
      end
      if (out_pc_q[2] !== 32'h3000_0100 || out_fault_q[2] !== 1'b0) begin
         errors++;
         $display("FAIL flt_out2 got %h f %b exp 30000100 f 0", out_pc_q[2], out_fault_q[2]);
      end
      if (out_pc_q[3] !== 32'h3000_0104) begin errors++; $display("FAIL flt_out3 got %h exp 30000104", out_pc_q[3]); end
   endtask

   task automatic test_async_reset();
      do_reset(1'b0, 5, 1'b0, 32'd0);
      tick();
      checks++;
      if (axi_arvalid !== 1'b1) begin errors++; $display("FAIL arst_pre_arvalid got %b exp 1", axi_arvalid); end
      reset = 1'b0;
      #1;
      checks++;
      if (axi_arvalid !== 1'b0) begin errors++; $display("FAIL arst_arvalid got %b exp 0", axi_arvalid); end
      do_reset(1'b0, 0, 1'b0, 32'd0);
      wait_beats(2, 50);
      checks += 2;
      if (axi_rready !== 1'b1) begin errors++; $display("FAIL arst_pre_rready got %b exp 1", axi_rready); end
      if (if_out_valid !== 1'b1) begin errors++; $display("FAIL arst_pre_valid got %b exp 1", if_out_valid); end
      reset = 1'b0;
      #1;
      checks += 3;
      if (axi_rready !== 1'b0) begin errors++; $display("FAIL arst_rready got %b exp 0", axi_rready); end
      if (if_out_valid !== 1'b0) begin errors++; $display("FAIL arst_valid got %b exp 0", if_out_valid); end
      if (pc_F !== 32'd0) begin errors++; $display("FAIL arst_pc got %h exp 0", pc_F); end
      do_reset(1'b1, 0, 1'b0, 32'd0);
      tick();
      checks++;
      if (axi_arvalid !== 1'b1 || axi_araddr !== 32'h3000_0000) begin
         errors++;
         $display("FAIL arst_ar got v %b addr %h exp 1 30000000", axi_arvalid, axi_araddr);
      end
      wait_out(1, 100);
      checks++;
      if (out_pc_q[0] !== 32'h3000_0000) begin errors++; $display("FAIL arst_out got %h exp 30000000", out_pc_q[0]); end
   endtask

   initial begin
      reset = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc = '0;
      if_out_ready = 1'b0;
      fault_en = 1'b0;
      fault_addr = '0;
      ar_stall = 0;
      beats_fired = 0;
      test_reset();
      test_streaming();
      test_backpressure();
      test_redirect_mid_burst();
      test_redirect_in_ar();
      test_fault();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
